// File: rtl/chess_pkg.sv
// chess_pkg: shared encodings for the move-generation sequencer and the board.
//   - state_mode_e : board search command (IDLE/FIND_VICTIM/FIND_AGGR/TEST_MOVE)
//   - mask_mode_e  : board mask command (NONE/CLEAR/MASK_VICTIM/MASK_AGGR)
//   - brd_data field positions (bit 6 = found, bits 5:0 = square)
//   - seq_state_e  : sequencer FSM states
//   - move_t       : {from_sq, to_sq} move record carried through the FIFO
package chess_pkg;

  localparam int SQ_W          = 6;
  localparam int BRD_FOUND_BIT = 6;
  localparam int BRD_SQ_MSB    = 5;
  localparam int BRD_SQ_LSB    = 0;

  typedef enum logic [2:0] {
    SM_IDLE        = 3'd0,
    SM_FIND_VICTIM = 3'd1,
    SM_FIND_AGGR   = 3'd2,
    SM_TEST_MOVE   = 3'd3
  } state_mode_e;

  typedef enum logic [1:0] {
    MM_NONE        = 2'd0,
    MM_CLEAR       = 2'd1,
    MM_MASK_VICTIM = 2'd2,
    MM_MASK_AGGR   = 2'd3
  } mask_mode_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_VREQ,
    ST_VWAIT,
    ST_AREQ,
    ST_AWAIT,
    ST_TREQ,
    ST_TWAIT,
    ST_PUSH,
    ST_AMASK,
    ST_VMASK,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [SQ_W-1:0] from_sq;
    logic [SQ_W-1:0] to_sq;
  } move_t;

endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO with valid/ready pop and show-ahead head output.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_data    write request and data (dropped if full with no pop)
//   i_pop             consumer ready; pops when the FIFO is non-empty
//   o_data            head entry (zero while empty)
//   o_valid, o_full   not-empty and full flags
module move_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_count == '0);
  assign o_full    = (r_count == OCC_W'(DEPTH));
  assign o_valid   = !w_empty;
  assign w_do_pop  = i_pop && !w_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/movegen_seq.sv
// movegen_seq: self-running move-generation scan over the 64-square board.
// Drives victim/aggressor search commands, masks found pieces and streams
// {aggressor, victim} moves out of a FIFO with valid/ready handshake.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, wtm_in                 scan request (IDLE only), side to move
//   busy, done                    scan in progress, one-cycle end pulse
//   state_mode, mask_mode, wtm    registered board command
//   ss1/ss1_valid, ss2/ss2_valid  board square selects
//   brd_data, brd_illegal         board result (BRD_LAT after the command)
//   mv_valid/mv_ready/mv_from/mv_to  move stream
//   mv_count                      moves pushed this scan, saturating
// Optional macro MOVEGEN_LEGAL_CHECK_EN: test each candidate with TEST_MOVE
// and drop moves the board flags illegal. Undefined: pseudo-legal moves only.
module movegen_seq
  import chess_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BRD_LAT    = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wtm_in,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_mode,
  output logic [1:0]       mask_mode,
  output logic             wtm,
  output logic [5:0]       ss1,
  output logic             ss1_valid,
  output logic [5:0]       ss2,
  output logic             ss2_valid,
  input  logic [6:0]       brd_data,
  input  logic             brd_illegal,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [5:0]       mv_from,
  output logic [5:0]       mv_to,
  output logic [CNT_W-1:0] mv_count
);
  localparam int WAIT_W = (BRD_LAT > 1) ? $clog2(BRD_LAT) : 1;
  localparam logic [WAIT_W-1:0] LAT_M1 = WAIT_W'(BRD_LAT - 1);

  seq_state_e       r_state;
  state_mode_e      r_state_mode;
  mask_mode_e       r_mask_mode;
  logic [WAIT_W-1:0] r_wait;
  logic [SQ_W-1:0]  r_victim;
  logic [SQ_W-1:0]  r_aggr;
  logic [SQ_W-1:0]  r_ss1;
  logic             r_ss1_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_wtm;
  logic [CNT_W-1:0] r_mv_count;

  logic             w_found;
  logic [SQ_W-1:0]  w_sq;
  logic             w_push;
  logic             w_fifo_full;
  move_t            w_move_in;
  move_t            w_move_head;

  assign w_found   = brd_data[BRD_FOUND_BIT];
  assign w_sq      = brd_data[BRD_SQ_MSB:BRD_SQ_LSB];
  assign w_move_in = '{from_sq: r_aggr, to_sq: r_victim};
  // PUSH advances only when the entry is actually accepted.
  assign w_push    = (r_state == ST_PUSH) && (!w_fifo_full || (mv_valid && mv_ready));

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(move_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_move_in),
    .i_pop   (mv_ready),
    .o_data  (w_move_head),
    .o_valid (mv_valid),
    .o_full  (w_fifo_full)
  );

  assign mv_from    = w_move_head.from_sq;
  assign mv_to      = w_move_head.to_sq;
  assign state_mode = r_state_mode;
  assign mask_mode  = r_mask_mode;
  assign ss1        = r_ss1;
  assign ss1_valid  = r_ss1_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign wtm        = r_wtm;
  assign mv_count   = r_mv_count;

`ifdef MOVEGEN_LEGAL_CHECK_EN
  logic [SQ_W-1:0] r_ss2;
  logic            r_ss2_valid;
  assign ss2       = r_ss2;
  assign ss2_valid = r_ss2_valid;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = brd_illegal;
  assign ss2       = '0;
  assign ss2_valid = 1'b0;
`endif

  // Command outputs are loaded on the edge that enters a state, so each
  // command is on the ports during exactly that state's cycle; the defaults
  // below return the ports to NONE/IDLE on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_state_mode <= SM_IDLE;
      r_mask_mode  <= MM_NONE;
      r_wait       <= '0;
      r_victim     <= '0;
      r_aggr       <= '0;
      r_ss1        <= '0;
      r_ss1_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wtm        <= 1'b0;
      r_mv_count   <= '0;
`ifdef MOVEGEN_LEGAL_CHECK_EN
      r_ss2        <= '0;
      r_ss2_valid  <= 1'b0;
`endif
    end else begin
      r_state_mode <= SM_IDLE;
      r_mask_mode  <= MM_NONE;
      r_ss1_valid  <= 1'b0;
      r_done       <= 1'b0;
`ifdef MOVEGEN_LEGAL_CHECK_EN
      r_ss2_valid  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_wtm       <= wtm_in;
            r_mv_count  <= '0;
            r_busy      <= 1'b1;
            r_mask_mode <= MM_CLEAR;
            r_state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_state_mode <= SM_FIND_VICTIM;
          r_state      <= ST_VREQ;
        end
        ST_VREQ: begin
          r_wait  <= LAT_M1;
          r_state <= ST_VWAIT;
        end
        ST_VWAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else if (w_found) begin
            r_victim     <= w_sq;
            r_state_mode <= SM_FIND_AGGR;
            r_ss1        <= w_sq;
            r_ss1_valid  <= 1'b1;
            r_state      <= ST_AREQ;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_AREQ: begin
          r_wait  <= LAT_M1;
          r_state <= ST_AWAIT;
        end
        ST_AWAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else if (w_found) begin
            r_aggr <= w_sq;
`ifdef MOVEGEN_LEGAL_CHECK_EN
            r_state_mode <= SM_TEST_MOVE;
            r_ss1        <= w_sq;
            r_ss1_valid  <= 1'b1;
            r_ss2        <= r_victim;
            r_ss2_valid  <= 1'b1;
            r_state      <= ST_TREQ;
`else
            r_state <= ST_PUSH;
`endif
          end else begin
            // Victim exhausted: masking it also releases the aggressor masks.
            r_mask_mode <= MM_MASK_VICTIM;
            r_ss1       <= r_victim;
            r_ss1_valid <= 1'b1;
            r_state     <= ST_VMASK;
          end
        end
`ifdef MOVEGEN_LEGAL_CHECK_EN
        ST_TREQ: begin
          r_wait  <= LAT_M1;
          r_state <= ST_TWAIT;
        end
        ST_TWAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else if (brd_illegal) begin
            r_mask_mode <= MM_MASK_AGGR;
            r_ss1       <= r_aggr;
            r_ss1_valid <= 1'b1;
            r_state     <= ST_AMASK;
          end else begin
            r_state <= ST_PUSH;
          end
        end
`endif
        ST_PUSH: begin
          if (w_push) begin
            if (r_mv_count != '1) r_mv_count <= r_mv_count + 1'b1;
            r_mask_mode <= MM_MASK_AGGR;
            r_ss1       <= r_aggr;
            r_ss1_valid <= 1'b1;
            r_state     <= ST_AMASK;
          end
        end
        ST_AMASK: begin
          r_state_mode <= SM_FIND_AGGR;
          r_ss1        <= r_victim;
          r_ss1_valid  <= 1'b1;
          r_state      <= ST_AREQ;
        end
        ST_VMASK: begin
          r_state_mode <= SM_FIND_VICTIM;
          r_state      <= ST_VREQ;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_movegen_seq.sv
`timescale 1ns/1ps
module tb_movegen_seq;
  localparam int FIFO_DEPTH = 8;
  localparam int BRD_LAT    = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef MOVEGEN_LEGAL_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             wtm_in = 1'b0;
  logic             busy, done, wtm;
  logic [2:0]       state_mode;
  logic [1:0]       mask_mode;
  logic [5:0]       ss1, ss2;
  logic             ss1_valid, ss2_valid;
  logic [6:0]       brd_data;
  logic             brd_illegal;
  logic             mv_valid;
  logic             mv_ready = 1'b0;
  logic [5:0]       mv_from, mv_to;
  logic [CNT_W-1:0] mv_count;

  movegen_seq #(.FIFO_DEPTH(FIFO_DEPTH), .BRD_LAT(BRD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wtm_in(wtm_in),
    .busy(busy), .done(done), .state_mode(state_mode), .mask_mode(mask_mode),
    .wtm(wtm), .ss1(ss1), .ss1_valid(ss1_valid), .ss2(ss2), .ss2_valid(ss2_valid),
    .brd_data(brd_data), .brd_illegal(brd_illegal),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
    .mv_count(mv_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- Board model: pieces listed in priority order ----------
  int  nv;
  int  vic [8];
  int  na  [8];
  int  agg [8][8];
  bit  ill [8][8];
  bit  vmask [64];
  bit  amask [64];
  logic [6:0] dpipe [0:BRD_LAT] = '{default: '0};
  logic       ipipe [0:BRD_LAT] = '{default: 1'b0};
  int  n_amask = 0, n_vmask = 0, n_b2b = 0;
  bit  sm_prev = 0, mm_prev = 0;
  logic [6:0] bd_res;
  logic       bd_ill;
  bit         bd_hit;

  assign brd_data    = dpipe[BRD_LAT];
  assign brd_illegal = ipipe[BRD_LAT];

  always @(negedge clk) begin
    bd_res = '0;
    bd_ill = 1'b0;
    if (rst_n) begin
      if (mask_mode == 2'd1) begin
        for (int i = 0; i < 64; i++) begin vmask[i] = 0; amask[i] = 0; end
      end else if (mask_mode == 2'd2 && ss1_valid) begin
        vmask[ss1] = 1;
        for (int i = 0; i < 64; i++) amask[i] = 0;
        n_vmask++;
      end else if (mask_mode == 2'd3 && ss1_valid) begin
        amask[ss1] = 1;
        n_amask++;
      end
      bd_hit = 0;
      if (state_mode == 3'd1) begin
        for (int v = 0; v < nv; v++)
          if (!bd_hit && !vmask[vic[v]]) begin bd_hit = 1; bd_res = {1'b1, 6'(vic[v])}; end
      end else if (state_mode == 3'd2 && ss1_valid) begin
        for (int v = 0; v < nv; v++)
          if (vic[v] == int'(ss1))
            for (int a = 0; a < na[v]; a++)
              if (!bd_hit && !amask[agg[v][a]]) begin bd_hit = 1; bd_res = {1'b1, 6'(agg[v][a])}; end
      end else if (state_mode == 3'd3 && ss1_valid && ss2_valid) begin
        for (int v = 0; v < nv; v++)
          if (vic[v] == int'(ss2))
            for (int a = 0; a < na[v]; a++)
              if (agg[v][a] == int'(ss1)) bd_ill = ill[v][a];
      end
      if ((sm_prev && state_mode != 0) || (mm_prev && mask_mode != 0)) n_b2b++;
      sm_prev = (state_mode != 0);
      mm_prev = (mask_mode != 0);
    end
    for (int i = BRD_LAT; i > 0; i--) begin dpipe[i] = dpipe[i-1]; ipipe[i] = ipipe[i-1]; end
    dpipe[0] = bd_res;
    ipipe[0] = bd_ill;
  end

  // ---------------- Consumer ------------------------------------------------
  int         ready_mode = 0;   // 0 always ready, 1 random, 2 held low
  bit         saw_valid = 0;
  logic [11:0] rxq [$];
  logic [11:0] expq [$];

  always @(negedge clk) begin
    case (ready_mode)
      0:       mv_ready = 1'b1;
      1:       mv_ready = 1'($urandom_range(0, 1));
      default: mv_ready = 1'b0;
    endcase
    if (rst_n && mv_valid) saw_valid = 1;
    if (rst_n && mv_valid && mv_ready) rxq.push_back({mv_from, mv_to});
  end

  // ---------------- Reference model ----------------------------------------
  function automatic void build_expected();
    expq.delete();
    for (int v = 0; v < nv; v++)
      for (int a = 0; a < na[v]; a++)
        if (!LC || !ill[v][a]) expq.push_back({6'(agg[v][a]), 6'(vic[v])});
  endfunction

  function automatic int total_aggr();
    int t = 0;
    for (int v = 0; v < nv; v++) t += na[v];
    return t;
  endfunction

  // Scan length from CLEAR through DONE when the consumer never stalls.
  function automatic int exp_cycles();
    int t = 1 + (1 + BRD_LAT) + 1;
    for (int v = 0; v < nv; v++) begin
      t += (1 + BRD_LAT) + (1 + BRD_LAT) + 1;
      for (int a = 0; a < na[v]; a++)
        t += (1 + BRD_LAT) + (LC ? 1 + BRD_LAT : 0) + ((LC && ill[v][a]) ? 0 : 1) + 1;
    end
    return t;
  endfunction

  task automatic gen_random(input int nvv, input int amin, input int amax);
    bit used_v [64];
    bit used_a [64];
    int sq;
    for (int i = 0; i < 64; i++) used_v[i] = 0;
    nv = nvv;
    for (int v = 0; v < nv; v++) begin
      do sq = $urandom_range(0, 63); while (used_v[sq]);
      used_v[sq] = 1;
      vic[v] = sq;
      for (int i = 0; i < 64; i++) used_a[i] = 0;
      used_a[sq] = 1;
      na[v] = $urandom_range(amin, amax);
      for (int a = 0; a < na[v]; a++) begin
        do sq = $urandom_range(0, 63); while (used_a[sq]);
        used_a[sq] = 1;
        agg[v][a] = sq;
        ill[v][a] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic run_scan(input string tag, input int mode, input bit poke);
    int cyc, lw, nexp, nchk;
    bit w;
    build_expected();
    nexp = expq.size();
    rxq.delete();
    saw_valid = 0;
    n_amask = 0;
    n_vmask = 0;
    ready_mode = mode;
    w = 1'($urandom_range(0, 1));
    @(negedge clk); wtm_in = w; start = 1'b1;
    @(negedge clk); start = 1'b0; wtm_in = ~w;
    cyc = 1;
    check_eq({tag, "_busy_start"}, 32'(busy), 1);
    check_eq({tag, "_wtm"}, 32'(wtm), 32'(w));
    while (!done && cyc < 3000) begin
      if (poke) start = (cyc >= 4 && cyc < 7);
      if (mode == 2 && cyc == 400) begin
        check_eq({tag, "_stall_count"}, 32'(mv_count), (nexp < FIFO_DEPTH) ? nexp : FIFO_DEPTH);
        check_eq({tag, "_stall_busy"}, 32'(busy), (nexp > FIFO_DEPTH) ? 1 : 0);
        check_eq({tag, "_stall_rx"}, rxq.size(), 0);
        ready_mode = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(done), 1);
    check_eq({tag, "_busy_at_done"}, 32'(busy), 0);
    if (mode == 0) check_eq({tag, "_cycles"}, cyc, exp_cycles());
    check_eq({tag, "_mv_count"}, 32'(mv_count), (nexp < CNT_MAX) ? nexp : CNT_MAX);
    check_eq({tag, "_n_mask_aggr"}, n_amask, total_aggr());
    check_eq({tag, "_n_mask_victim"}, n_vmask, nv);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 0);
    check_eq({tag, "_busy_idle"}, 32'(busy), 0);
    if (mode == 2) ready_mode = 0;
    lw = 0;
    while (mv_valid && lw < 300) begin @(negedge clk); lw++; end
    check_eq({tag, "_drained"}, 32'(mv_valid), 0);
    check_eq({tag, "_n_moves"}, rxq.size(), nexp);
    nchk = (rxq.size() < nexp) ? rxq.size() : nexp;
    for (int i = 0; i < nchk; i++) check_eq({tag, "_move"}, 32'(rxq[i]), 32'(expq[i]));
    check_eq({tag, "_saw_valid"}, 32'(saw_valid), (nexp > 0) ? 1 : 0);
    $display("scan %s: %0d victims, %0d moves expected, %0d received, %0d cycles",
             tag, nv, nexp, rxq.size(), cyc);
  endtask

  task automatic run_reset_mid();
    int lw;
    gen_random(1, 6, 6);
    for (int a = 0; a < 8; a++) ill[0][a] = 0;
    rxq.delete();
    ready_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lw = 0;
    while (mv_count < 3 && lw < 500) begin @(negedge clk); lw++; end
    check_eq("rst_pre_count", 32'(mv_count), 3);
    lw = 0;
    while (state_mode != 3'd2 && lw < 50) begin @(negedge clk); lw++; end
    check_eq("rst_pre_areq", 32'(state_mode), 2);
    check_eq("rst_pre_valid", 32'(mv_valid), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mv_valid", 32'(mv_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_mv_count", 32'(mv_count), 0);
    check_eq("rst_state_mode", 32'(state_mode), 0);
    check_eq("rst_mask_mode", 32'(mask_mode), 0);
    check_eq("rst_ss1_valid", 32'(ss1_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    rxq.delete();
    ready_mode = 0;
    @(negedge clk);
    check_eq("rst_after_valid", 32'(mv_valid), 0);
    run_scan("post_rst", 0, 0);
  endtask

  initial begin
    nv = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_done", 32'(done), 0);
    check_eq("reset_state_mode", 32'(state_mode), 0);
    check_eq("reset_mask_mode", 32'(mask_mode), 0);
    check_eq("reset_ss1_valid", 32'(ss1_valid), 0);
    check_eq("reset_ss2_valid", 32'(ss2_valid), 0);
    check_eq("reset_mv_valid", 32'(mv_valid), 0);
    check_eq("reset_mv_count", 32'(mv_count), 0);
    check_eq("reset_move", 32'({mv_from, mv_to}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty board.
    nv = 0;
    run_scan("empty", 0, 0);

    // One victim on 36 attacked from 28 then 12; (28,36) flagged illegal.
    nv = 1; vic[0] = 36; na[0] = 2;
    agg[0][0] = 28; ill[0][0] = 1;
    agg[0][1] = 12; ill[0][1] = 0;
    run_scan("directed", 0, 0);

    // Ten moves against a stalled consumer.
    gen_random(2, 5, 5);
    for (int v = 0; v < 2; v++) for (int a = 0; a < 8; a++) ill[v][a] = 0;
    run_scan("hold", 2, 0);

    // Saturating move counter.
    gen_random(4, 6, 6);
    for (int v = 0; v < 4; v++) for (int a = 0; a < 8; a++) ill[v][a] = 0;
    run_scan("saturate", 0, 0);

    // start pulsed while busy must be ignored.
    gen_random(2, 1, 3);
    run_scan("start_busy", 0, 1);

    run_reset_mid();

    for (int it = 0; it < 12; it++) begin
      gen_random($urandom_range(0, 4), 0, 6);
      run_scan($sformatf("rand%0d", it), $urandom_range(0, 1), (it % 3 == 0) && (nv > 0));
    end

    check_eq("cmd_one_cycle", n_b2b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
